// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Package    : riscv_pkg
//  Description: Shared RV32I load/store funct3 codes, LSU FSM state encoding
//               and small helpers for byte-enable / store-data formatting.
//  Revision   : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Load width/sign codes
    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lh  = 3'b001;
    localparam logic [2:0] c_f3_lw  = 3'b010;
    localparam logic [2:0] c_f3_lbu = 3'b100;
    localparam logic [2:0] c_f3_lhu = 3'b101;

    // Store width codes
    localparam logic [2:0] c_f3_sb  = 3'b000;
    localparam logic [2:0] c_f3_sh  = 3'b001;
    localparam logic [2:0] c_f3_sw  = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_t;

    function automatic logic load_f3_legal(input logic [2:0] f3);
        return (f3 == c_f3_lb) || (f3 == c_f3_lh) || (f3 == c_f3_lw) ||
               (f3 == c_f3_lbu) || (f3 == c_f3_lhu);
    endfunction

    function automatic logic store_f3_legal(input logic [2:0] f3);
        return (f3 == c_f3_sb) || (f3 == c_f3_sh) || (f3 == c_f3_sw);
    endfunction

    // size = funct3[1:0]: 00 byte, 01 half, 10 word
    function automatic logic [3:0] access_be(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the store operand across every lane it may land in
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b01:   return lo[0];
            2'b10:   return (lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Interface  : load_store_unit_if
//  Description: Data-memory request/response bus between the LSU (master)
//               and the memory (slave).
//    dmem_req/we/addr/be/wdata : request, held stable until dmem_gnt
//    dmem_gnt                  : request accepted
//    dmem_rvalid/rdata         : response, at least one cycle after gnt
//  Revision   : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit_load_align.sv
`default_nettype none
// ============================================================================
//  Module     : lsu_load_align
//  Description: Combinational load-data aligner. Selects the byte/half lane
//               from the low address bits and sign/zero extends per funct3.
//    i_rdata   : raw 32-bit word from memory
//    i_addr_lo : address bits [1:0]
//    i_funct3  : RV32I load code
//    o_data    : aligned, extended result
//  Revision   : 1.0 - initial release
// ============================================================================
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Halfwords use addr[1] only; addr[0] is don't-care for them.
    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            c_f3_lb:  o_data = {{24{w_byte[7]}}, w_byte};
            c_f3_lh:  o_data = {{16{w_half[15]}}, w_half};
            c_f3_lbu: o_data = {24'd0, w_byte};
            c_f3_lhu: o_data = {16'd0, w_half};
            default:  o_data = i_rdata;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module     : load_store_unit
//  Description: RV32I load/store unit. Accepts one access from execute,
//               issues it on the dmem bus, waits for the response and
//               returns aligned load data through a one-cycle writeback pulse.
//    clk, rst_n        : clock, asynchronous active-low reset
//    ex_*              : access from execute (valid, read/write, funct3,
//                        address, store data, destination register)
//    lsu_busy          : stall while not IDLE
//    dmem              : memory bus (load_store_unit_if.master)
//    wb_valid/rd_idx/data : load completion
//    lsu_err           : one-cycle pulse on illegal access or timeout
//  Options    : LSU_MISALIGN_TRAP_EN - reject misaligned half/word accesses
//  Revision   : 1.0 - initial release
// ============================================================================
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [2:0]        ex_funct3,
    input  logic [31:0]       ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic [4:0]        ex_rd_idx,
    output logic              lsu_busy,
    load_store_unit_if.master dmem,
    output logic              wb_valid,
    output logic [4:0]        wb_rd_idx,
    output logic [31:0]       wb_data,
    output logic              lsu_err
);
    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_t  r_state;
    lsu_state_t  w_next;
    logic [7:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_wb_data;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd_idx;
    logic        r_we;
    logic        r_err;

    logic        w_is_idle;
    logic        w_in_req;
    logic        w_cmd;
    logic        w_f3_ok;
    logic        w_align_ok;
    logic        w_accept;
    logic        w_reject;
    logic        w_tmo;
    logic        w_abort;
    logic        w_capture;
    logic [31:0] w_load_data;

    assign w_is_idle = (r_state == LSU_IDLE);
    assign w_in_req  = (r_state == LSU_REQ);
    assign w_cmd     = ex_valid & (ex_mem_read | ex_mem_write);
    assign w_f3_ok   = ex_mem_write ? store_f3_legal(ex_funct3) : load_f3_legal(ex_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_align_ok = ~misaligned(ex_funct3[1:0], ex_addr[1:0]);
`else
    assign w_align_ok = 1'b1;
`endif

    // Read and write together is rejected along with illegal codes.
    assign w_accept = w_is_idle & w_cmd & (ex_mem_read ^ ex_mem_write) & w_f3_ok & w_align_ok;
    assign w_reject = w_is_idle & w_cmd & ~w_accept;
    assign w_tmo    = (r_cnt == c_tmo_last);

    // Next-state logic. In REQ the timeout wins over a same-cycle grant so
    // REQ+WAIT never exceeds TIMEOUT_CYCLES; a late grant's response is then
    // simply ignored in IDLE. In WAIT a response on the last cycle completes.
    always_comb begin
        w_next    = r_state;
        w_abort   = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            LSU_IDLE: begin
                if (w_accept) w_next = LSU_REQ;
            end
            LSU_REQ: begin
                if (w_tmo) begin
                    w_next  = LSU_IDLE;
                    w_abort = 1'b1;
                end else if (dmem.dmem_gnt) begin
                    w_next = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (dmem.dmem_rvalid) begin
                    if (r_we) begin
                        w_next = LSU_IDLE;
                    end else begin
                        w_next    = LSU_DONE;
                        w_capture = 1'b1;
                    end
                end else if (w_tmo) begin
                    w_next  = LSU_IDLE;
                    w_abort = 1'b1;
                end
            end
            LSU_DONE: w_next = LSU_IDLE;
            default:  w_next = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= LSU_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wb_data <= '0;
            r_funct3  <= '0;
            r_rd_idx  <= '0;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_reject | w_abort;
            if ((r_state == LSU_REQ) || (r_state == LSU_WAIT)) begin
                r_cnt <= r_cnt + 8'd1;
            end else begin
                r_cnt <= '0;
            end
            if (w_accept) begin
                r_addr   <= ex_addr;
                r_wdata  <= ex_wdata;
                r_funct3 <= ex_funct3;
                r_rd_idx <= ex_rd_idx;
                r_we     <= ex_mem_write;
            end
            if (w_capture) begin
                r_wb_data <= w_load_data;
            end
        end
    end

    lsu_load_align u_load_align (
        .i_rdata   (dmem.dmem_rdata),
        .i_addr_lo (r_addr[1:0]),
        .i_funct3  (r_funct3),
        .o_data    (w_load_data)
    );

    // Bus and writeback outputs are gated by state so reset zeroes them at once.
    assign lsu_busy        = ~w_is_idle;
    assign dmem.dmem_req   = w_in_req;
    assign dmem.dmem_we    = w_in_req & r_we;
    assign dmem.dmem_addr  = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
    assign dmem.dmem_be    = w_in_req ? access_be(r_funct3[1:0], r_addr[1:0]) : 4'd0;
    assign dmem.dmem_wdata = (w_in_req & r_we) ? store_data(r_funct3[1:0], r_wdata) : 32'd0;
    assign wb_valid        = (r_state == LSU_DONE);
    assign wb_rd_idx       = wb_valid ? r_rd_idx : 5'd0;
    assign wb_data         = wb_valid ? r_wb_data : 32'd0;
    assign lsu_err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module     : tb_load_store_unit
//  Description: Self-checking bench for load_store_unit: table of directed
//               single accesses plus hand sequences for held grant, stale
//               rvalid, busy-ignore, timeouts and reset in WAIT.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd_idx;
        logic        exp_err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic        ex_mem_write = 1'b0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic [31:0] ex_addr = 32'd0;
    logic [31:0] ex_wdata = 32'd0;
    logic [4:0]  ex_rd_idx = 5'd0;
    logic        lsu_busy;
    logic        wb_valid;
    logic [4:0]  wb_rd_idx;
    logic [31:0] wb_data;
    logic        lsu_err;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'd0;

    int total = 0;
    int bad = 0;
    vec_t vq[$];

    load_store_unit_if bus();
    assign bus.dmem_gnt    = gnt;
    assign bus.dmem_rvalid = rvalid;
    assign bus.dmem_rdata  = rdata;

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_funct3    (ex_funct3),
        .ex_addr      (ex_addr),
        .ex_wdata     (ex_wdata),
        .ex_rd_idx    (ex_rd_idx),
        .lsu_busy     (lsu_busy),
        .dmem         (bus),
        .wb_valid     (wb_valid),
        .wb_rd_idx    (wb_rd_idx),
        .wb_data      (wb_data),
        .lsu_err      (lsu_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: actual=%h required=%h", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rdi);
        ex_valid     = 1'b1;
        ex_mem_read  = rd;
        ex_mem_write = wr;
        ex_funct3    = f3;
        ex_addr      = addr;
        ex_wdata     = wd;
        ex_rd_idx    = rdi;
    endtask

    task automatic idle_ex();
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        tick();
        drive(v.rd, v.wr, v.f3, v.addr, v.wdata, v.rd_idx);
        tick();
        idle_ex();
        if (v.exp_err) begin
            chk("err_pulse", i, {31'd0, lsu_err}, 32'd1);
            chk("err_noreq_busy", i, {30'd0, bus.dmem_req, lsu_busy}, 32'd0);
            tick();
            chk("err_oneshot", i, {30'd0, lsu_err, lsu_busy}, 32'd0);
        end else begin
            chk("req", i, {31'd0, bus.dmem_req}, 32'd1);
            chk("addr", i, bus.dmem_addr, v.exp_addr);
            chk("we", i, {31'd0, bus.dmem_we}, {31'd0, v.wr});
            if (v.wr) begin
                chk("be", i, {28'd0, bus.dmem_be}, {28'd0, v.exp_be});
                chk("wdata", i, bus.dmem_wdata, v.exp_wdata);
            end
            gnt = 1'b1;
            tick();
            gnt = 1'b0;
            chk("req_drop", i, {31'd0, bus.dmem_req}, 32'd0);
            rvalid = 1'b1;
            rdata  = v.rdata;
            tick();
            rvalid = 1'b0;
            rdata  = 32'd0;
            if (v.rd) begin
                chk("wb_valid", i, {31'd0, wb_valid}, 32'd1);
                chk("wb_data", i, wb_data, v.exp_data);
                chk("wb_rd_idx", i, {27'd0, wb_rd_idx}, {27'd0, v.rd_idx});
                tick();
                chk("after_done", i, {30'd0, wb_valid, lsu_busy}, 32'd0);
            end else begin
                chk("store_nowb", i, {30'd0, wb_valid, lsu_busy}, 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // rd, wr, f3, addr, wdata, rdata, rd_idx, err, exp_addr, exp_be, exp_wdata, exp_data
        vq.push_back('{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 5'd1, 1'b0, 32'h0000_0100, 4'h0, 32'h0, 32'hFFFF_FF80});
        vq.push_back('{1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0, 32'h1234_8056, 5'd2, 1'b0, 32'h0000_0100, 4'h0, 32'h0, 32'h0000_0080});
        vq.push_back('{1'b1, 1'b0, 3'b001, 32'h0000_0042, 32'h0, 32'h8001_7FFF, 5'd3, 1'b0, 32'h0000_0040, 4'h0, 32'h0, 32'hFFFF_8001});
        vq.push_back('{1'b1, 1'b0, 3'b101, 32'h0000_0040, 32'h0, 32'h8001_F00D, 5'd4, 1'b0, 32'h0000_0040, 4'h0, 32'h0, 32'h0000_F00D});
        vq.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 5'd5, 1'b0, 32'h0000_1000, 4'h0, 32'h0, 32'hDEAD_BEEF});
        vq.push_back('{1'b1, 1'b0, 3'b001, 32'h0000_0010, 32'h0, 32'h0000_1234, 5'd31, 1'b0, 32'h0000_0010, 4'h0, 32'h0, 32'h0000_1234});
        vq.push_back('{1'b0, 1'b1, 3'b000, 32'h0000_0301, 32'h1234_56A5, 32'h0, 5'd0, 1'b0, 32'h0000_0300, 4'b0010, 32'hA5A5_A5A5, 32'h0});
        vq.push_back('{1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 5'd0, 1'b0, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0});
        vq.push_back('{1'b0, 1'b1, 3'b010, 32'h0000_0404, 32'hCAFE_F00D, 32'h0, 5'd0, 1'b0, 32'h0000_0404, 4'b1111, 32'hCAFE_F00D, 32'h0});
        vq.push_back('{1'b0, 1'b1, 3'b000, 32'h0000_0003, 32'h0000_00FF, 32'h0, 5'd0, 1'b0, 32'h0000_0000, 4'b1000, 32'hFFFF_FFFF, 32'h0});
        vq.push_back('{1'b0, 1'b1, 3'b001, 32'h0000_0000, 32'h1234_5678, 32'h0, 5'd0, 1'b0, 32'h0000_0000, 4'b0011, 32'h5678_5678, 32'h0});
        vq.push_back('{1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 5'd6, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0});
        vq.push_back('{1'b1, 1'b0, 3'b110, 32'h0000_0100, 32'h0, 32'h0, 5'd6, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0});
        vq.push_back('{1'b0, 1'b1, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 5'd0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0});
        vq.push_back('{1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 5'd6, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0});
`ifdef LSU_MISALIGN_TRAP_EN
        vq.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h1122_3344, 5'd7, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0});
`else
        vq.push_back('{1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h1122_3344, 5'd7, 1'b0, 32'h0000_0004, 4'h0, 32'h0, 32'h1122_3344});
`endif

        // Reset state
        #1;
        chk("rst_ctl", 0, {23'd0, bus.dmem_req, bus.dmem_we, bus.dmem_be, lsu_busy, wb_valid, lsu_err}, 32'd0);
        chk("rst_addr", 0, bus.dmem_addr, 32'd0);
        chk("rst_data", 0, bus.dmem_wdata | wb_data | {27'd0, wb_rd_idx}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            run_vec(i, vq[i]);
        end

        // Grant withheld 5 cycles; stale rvalid in REQ and a new ex_valid are ignored
        tick();
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 5'd9);
        for (int k = 1; k <= 5; k++) begin
            tick();
            idle_ex();
            rvalid = 1'b0;
            chk("hold_req", k, {31'd0, bus.dmem_req}, 32'd1);
            chk("hold_addr", k, bus.dmem_addr, 32'h0000_0500);
            chk("hold_nowb", k, {31'd0, wb_valid}, 32'd0);
            if (k == 2) begin
                rvalid = 1'b1;
                rdata  = 32'h0000_0BAD;
            end
            if (k == 3) drive(1'b0, 1'b1, 3'b010, 32'h0000_0999, 32'h1, 5'd0);
        end
        gnt = 1'b1;
        tick();
        gnt    = 1'b0;
        rvalid = 1'b1;
        rdata  = 32'h0A0B_0C0D;
        tick();
        rvalid = 1'b0;
        rdata  = 32'd0;
        chk("hold_wb", 0, {31'd0, wb_valid}, 32'd1);
        chk("hold_wb_data", 0, wb_data, 32'h0A0B_0C0D);
        tick();
        chk("hold_no_second", 0, {30'd0, lsu_busy, bus.dmem_req}, 32'd0);

        // Timeout in REQ (grant never arrives)
        tick();
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0, 5'd10);
        for (int k = 1; k <= 16; k++) begin
            tick();
            idle_ex();
            chk("tmo_req_busy", k, {30'd0, bus.dmem_req, lsu_err}, 32'd2);
        end
        tick();
        chk("tmo_req_err", 0, {29'd0, lsu_err, lsu_busy, bus.dmem_req}, 32'd4);
        tick();
        chk("tmo_req_oneshot", 0, {31'd0, lsu_err}, 32'd0);

        // Timeout in WAIT (granted, response never arrives), then late rvalid
        tick();
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0604, 32'h0, 5'd11);
        tick();
        idle_ex();
        gnt = 1'b1;
        for (int k = 2; k <= 16; k++) begin
            tick();
            gnt = 1'b0;
            chk("tmo_wait_busy", k, {30'd0, lsu_busy, lsu_err}, 32'd2);
        end
        tick();
        chk("tmo_wait_err", 0, {30'd0, lsu_err, lsu_busy}, 32'd2);
        rvalid = 1'b1;
        rdata  = 32'h5555_5555;
        tick();
        rvalid = 1'b0;
        chk("late_rvalid", 0, {30'd0, wb_valid, lsu_busy}, 32'd0);

        // Reset asserted while in WAIT
        tick();
        drive(1'b1, 1'b0, 3'b010, 32'h0000_0700, 32'h0, 5'd12);
        tick();
        idle_ex();
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        chk("wait_busy", 0, {31'd0, lsu_busy}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_wait_ctl", 0, {23'd0, bus.dmem_req, bus.dmem_we, bus.dmem_be, lsu_busy, wb_valid, lsu_err}, 32'd0);
        chk("rst_wait_data", 0, bus.dmem_addr | bus.dmem_wdata | wb_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rvalid = 1'b1;
        rdata  = 32'h7777_7777;
        tick();
        rvalid = 1'b0;
        chk("rst_wait_nowb", 0, {30'd0, wb_valid, lsu_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: max cycles in REQ+WAIT before abort; legal range 2..255.
REQ-002 One clock; reset is asynchronous and active-low; ports `clk` and `rst_n` listed first.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 ex_valid  input  1  execute stage presents an access this cycle.
REQ-006 ex_mem_read / ex_mem_write  input  1 each  load / store request.
REQ-007 ex_funct3  input  3  RV32I width/sign code (LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010).
REQ-008 ex_addr  input  32  effective address (ALU result); ex_wdata  input  32  store data (rs2); ex_rd_idx  input  5  load destination.
REQ-009 lsu_busy  output  1  pipeline stall; high whenever state is not IDLE.
REQ-010 dmem_req, dmem_we  output  1 each; dmem_addr  output  32  word-aligned ({addr[31:2],2'b00}); dmem_be  output  4; dmem_wdata  output  32.
REQ-011 dmem_gnt, dmem_rvalid  input  1 each; dmem_rdata  input  32.
REQ-012 wb_valid  output  1  one-cycle load-complete pulse; wb_rd_idx  output  5; wb_data  output  32; lsu_err  output  1  one-cycle error pulse.

Function
REQ-013 FSM states IDLE, REQ, WAIT, DONE; an access is accepted only in IDLE when ex_valid and exactly one of ex_mem_read/ex_mem_write is 1.
REQ-014 Accept at edge T latches addr, wdata, funct3, rd_idx, direction; state becomes REQ at T+1.
REQ-015 In REQ, dmem_req=1, all dmem_* held stable until dmem_gnt=1; on gnt, go to WAIT.
REQ-016 dmem_rvalid is sampled only in WAIT; in REQ it is ignored (memory contract: rvalid at least 1 cycle after gnt).
REQ-017 On rvalid in WAIT: load -> DONE, capturing aligned/extended data; store -> IDLE, no wb_valid.
REQ-018 DONE lasts exactly one cycle with wb_valid=1, wb_data and wb_rd_idx valid, then IDLE; minimum load latency accept->wb_valid = 3 cycles (gnt at T+1, rvalid at T+2, wb_valid at T+3).
REQ-019 Store encoding: SB be=4'b0001<<addr[1:0], wdata byte replicated x4; SH be=addr[1]?1100:0011, halfword replicated x2; SW be=1111.
REQ-020 Load extraction: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-021 Illegal funct3 (loads 011/110/111, stores >=011) or ex_mem_read and ex_mem_write both 1 with ex_valid -> lsu_err pulse next cycle, no bus request, stay IDLE.
REQ-022 Timeout counter clears on accept, increments each cycle in REQ/WAIT; reaching TIMEOUT_CYCLES -> lsu_err pulse, dmem_req drops, IDLE, no wb_valid; late rvalid in IDLE ignored.
REQ-023 ex_valid while busy is ignored; upstream must hold via lsu_busy.

Reset
REQ-024 rst_n low forces IDLE immediately (mid-transaction included); dmem_req, dmem_we, wb_valid, lsu_err, lsu_busy = 0; dmem_be = 0; all data/address outputs = 0; counter = 0.

Configuration
REQ-025 Macro LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 -> lsu_err pulse next cycle, no bus request.
REQ-026 Macro undefined: no misalignment check; half uses addr[1] only, word ignores addr[1:0].

Structure
REQ-027 Shared package riscv_pkg holds funct3 load/store codes and LSU FSM state encodings; TIMEOUT_CYCLES stays a module parameter.
REQ-028 One combinational sub-module lsu_load_align (rdata, addr[1:0], funct3 -> extended 32-bit data).

Verification
REQ-029 LB addr=0x103, rdata=0x80FF_FF7F, gnt T+1, rvalid T+2 -> wb_valid at T+3, wb_data=0xFFFF_FF80.
REQ-030 SH addr=0x202, wdata=0x0000_ABCD -> dmem_addr=0x200, be=1100, dmem_wdata=0xABCD_ABCD, no wb_valid.
REQ-031 gnt withheld 5 cycles -> dmem_req and fields stable 5 cycles; gnt never, rvalid never -> lsu_err at TIMEOUT_CYCLES (16), IDLE.
REQ-032 LW addr=0x006: with LSU_MISALIGN_TRAP_EN -> lsu_err, no dmem_req; without -> dmem_addr=0x004, normal completion.
REQ-033 rst_n low while in WAIT -> all outputs 0 same cycle; later rvalid produces no wb_valid.
REQ-034 ex_valid with read=write=1, or load funct3=011 -> lsu_err pulse, lsu_busy stays 0.
